// File: rtl/m_ucode_store_pkg.sv
// Package: m_ucode_store_pkg
// Purpose:
//    Shared definitions for the microcode store: EBR slice geometry, the
//    loader state encoding, the word-width helper and the generated
//    microcode init image (one 16-bit column per slice).
// Contents:
//    EBR_W            width of one EBR slice
//    BYTES_PER_SLICE  loader bytes needed per slice
//    MAX_ADRW         widest address an EBR slice supports (2048x2 aspect)
//    ld_state_e       loader FSM states
//    ucode_word_width full microcode word width for a slice count
//    ucode_init_word  init contents of one slice at one address
package m_ucode_store_pkg;

   localparam int EBR_W           = 16;
   localparam int BYTES_PER_SLICE = 2;
   localparam int MAX_ADRW        = 11;

   typedef enum logic [1:0] {
      LD_IDLE    = 2'd0,
      LD_COLLECT = 2'd1,
      LD_WRITE   = 2'd2
   } ld_state_e;

   function automatic int ucode_word_width(input int nebr);
      return nebr * EBR_W;
   endfunction

   // Generated microcode image. The upper address bits only exist for the
   // wider EBR aspects and fold into the low byte so deep images stay distinct.
   function automatic logic [EBR_W-1:0] ucode_init_word(input int slice,
                                                        input logic [MAX_ADRW-1:0] addr);
      logic [7:0] hi;
      logic [7:0] lo;
      hi = addr[7:0] ^ 8'hA5;
      lo = (addr[7:0] + 8'(slice * 49)) ^ {5'b0, addr[10:8]};
      return {hi, lo};
   endfunction

endpackage

// File: rtl/m_ucode_store_slice.sv
// Module: m_ucode_store_slice
// Purpose:
//    One 16-bit EBR slice of the microcode store with a registered read
//    port and a simple write port. The EBR powers up zeroed, so each entry
//    holds the difference from the init image rather than the word itself:
//    an untouched entry reads back as the init word with nothing to preload,
//    and a write stores the new word XOR the init word for that address.
// Ports:
//    clk      in   1      system clock, rising edge
//    rd_en    in   1      read enable; 0 holds rd_data
//    rd_addr  in   ADRW   read address
//    rd_data  out  16     registered read data (old word on read/write collision)
//    wr_en    in   1      write enable
//    wr_addr  in   ADRW   write address
//    wr_data  in   16     write data
module m_ucode_store_slice
   import m_ucode_store_pkg::*;
#(
   parameter int SLICE = 0,
   parameter int ADRW  = 8
)(
   input  logic             clk,
   input  logic             rd_en,
   input  logic [ADRW-1:0]  rd_addr,
   output logic [EBR_W-1:0] rd_data,
   input  logic             wr_en,
   input  logic [ADRW-1:0]  wr_addr,
   input  logic [EBR_W-1:0] wr_data
);

   localparam int DEPTH = 1 << ADRW;

   logic [EBR_W-1:0] delta_mem [DEPTH];
   logic [EBR_W-1:0] rd_delta_q;
   logic [ADRW-1:0]  rd_addr_q;

   // EBR-style port: no reset on the array or the read register. The read
   // samples the array before the write lands, so a same-address collision
   // returns the previous word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         delta_mem[wr_addr] <= wr_data ^ ucode_init_word(SLICE, MAX_ADRW'(wr_addr));
      end
      if (rd_en) begin
         rd_delta_q <= delta_mem[rd_addr];
         rd_addr_q  <= rd_addr;
      end
   end

   // Unused EBR address MSBs are zero-extended into the image lookup.
   assign rd_data = rd_delta_q ^ ucode_init_word(SLICE, MAX_ADRW'(rd_addr_q));

endmodule

// File: rtl/m_ucode_store.sv
// Module: m_ucode_store
// Purpose:
//    Parametrised microcode store between the microcode sequencer and the
//    decode logic. NEBR 16-bit EBR slices side by side give one NEBR*16-bit
//    word per address, read with one cycle of latency. The output is forced
//    to 0 from reset until the first enabled read.
//    Optional feature macro: UCODE_PATCH_EN adds a byte-stream loader that
//    rewrites the store at run time, LS byte of each word first.
// Ports:
//    clk             in   1      system clock, rising edge
//    rst_n           in   1      asynchronous active-low reset
//    minx            in   ADRW   microcode read address
//    progress_ucode  in   1      read enable; 0 holds d
//    d               out  W      microcode word, W = 16*NEBR
//    ld_start        in   1      (UCODE_PATCH_EN) restart load at address 0
//    ld_valid        in   1      (UCODE_PATCH_EN) ld_byte valid
//    ld_byte         in   8      (UCODE_PATCH_EN) load data byte
//    ld_ready        out  1      (UCODE_PATCH_EN) loader accepts a byte this cycle
//    ld_busy         out  1      (UCODE_PATCH_EN) load in progress
module m_ucode_store
   import m_ucode_store_pkg::*;
#(
   parameter int NEBR = 3,
   parameter int ADRW = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADRW-1:0]       minx,
   input  logic                  progress_ucode,
   output logic [EBR_W*NEBR-1:0] d
`ifdef UCODE_PATCH_EN
   ,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   input  logic [7:0]            ld_byte,
   output logic                  ld_ready,
   output logic                  ld_busy
`endif
);

   localparam int W      = ucode_word_width(NEBR);
   localparam int NBYTES = NEBR * BYTES_PER_SLICE;

   logic [W-1:0]    rd_word;
   logic            wr_en;
   logic [ADRW-1:0] wr_addr;
   logic [W-1:0]    wr_data;
   logic            rd_valid_d;
   logic            rd_valid_q;

   for (genvar i = 0; i < NEBR; i++) begin : g_slice
      m_ucode_store_slice #(
         .SLICE (i),
         .ADRW  (ADRW)
      ) u_slice (
         .clk     (clk),
         .rd_en   (progress_ucode),
         .rd_addr (minx),
         .rd_data (rd_word[EBR_W*i +: EBR_W]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data[EBR_W*i +: EBR_W])
      );
   end

   // The EBR read registers have no reset, so this flag masks d to 0 from
   // reset until the first enabled read has refreshed them.
   always_comb begin
      rd_valid_d = rd_valid_q | progress_ucode;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
      end
   end

   assign d = rd_valid_q ? rd_word : '0;

`ifdef UCODE_PATCH_EN

   ld_state_e       st_d, st_q;
   logic [3:0]      bcnt_d, bcnt_q;
   logic [ADRW-1:0] addr_d, addr_q;
   logic [W-1:0]    word_d, word_q;
   logic            ld_ready_d, ld_ready_q;
   logic            ld_busy_d, ld_busy_q;

   // Loader next state. ld_start wins in every state: it discards whatever
   // is assembled (including a complete word still waiting in WRITE) and
   // restarts at address 0. The WRITE state wraps back to IDLE after the
   // last address, which leaves addr at 0 for the next load.
   always_comb begin
      st_d   = st_q;
      bcnt_d = bcnt_q;
      addr_d = addr_q;
      word_d = word_q;
      wr_en  = 1'b0;
      if (ld_start) begin
         st_d   = LD_COLLECT;
         bcnt_d = 4'd0;
         addr_d = '0;
         word_d = '0;
      end else begin
         case (st_q)
            LD_IDLE: begin
               st_d = LD_IDLE;
            end
            LD_COLLECT: begin
               if (ld_valid && ld_ready_q) begin
                  for (int b = 0; b < NBYTES; b++) begin
                     if (bcnt_q == 4'(b)) begin
                        word_d[8*b +: 8] = ld_byte;
                     end
                  end
                  if (bcnt_q == 4'(NBYTES - 1)) begin
                     bcnt_d = 4'd0;
                     st_d   = LD_WRITE;
                  end else begin
                     bcnt_d = bcnt_q + 4'd1;
                  end
               end
            end
            LD_WRITE: begin
               wr_en  = 1'b1;
               addr_d = addr_q + ADRW'(1);
               st_d   = (addr_q == '1) ? LD_IDLE : LD_COLLECT;
            end
            default: begin
               st_d = LD_IDLE;
            end
         endcase
      end
      ld_ready_d = (st_d == LD_COLLECT);
      ld_busy_d  = (st_d != LD_IDLE);
   end

   // Loader state and registered handshake outputs. Reset drops the
   // partial word; words already written stay in the EBRs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= LD_IDLE;
         bcnt_q     <= 4'd0;
         addr_q     <= '0;
         word_q     <= '0;
         ld_ready_q <= 1'b0;
         ld_busy_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         bcnt_q     <= bcnt_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         ld_ready_q <= ld_ready_d;
         ld_busy_q  <= ld_busy_d;
      end
   end

   assign wr_addr  = addr_q;
   assign wr_data  = word_q;
   assign ld_ready = ld_ready_q;
   assign ld_busy  = ld_busy_q;

`else

   // Pure ROM: the write port is tied off.
   assign wr_en   = 1'b0;
   assign wr_addr = '0;
   assign wr_data = '0;

`endif

endmodule

// File: tb/tb_m_ucode_store.sv
// Testbench: tb_m_ucode_store
// Purpose:
//    Self-checking bench for m_ucode_store (NEBR=3, ADRW=8). A vector table
//    and an address sweep drive reads; expected words are pushed to a
//    scoreboard queue as stimulus is applied and popped one cycle later when
//    d is sampled. Hand-written sequences cover reset masking, hold, and
//    asynchronous reset. With UCODE_PATCH_EN defined it also exercises the
//    byte loader: single word, aborted word, full load and reset mid-load.
module tb_m_ucode_store;

   localparam int NEBR = 3;
   localparam int ADRW = 8;
   localparam int W    = 16 * NEBR;

   logic            clk;
   logic            rst_n;
   logic [ADRW-1:0] minx;
   logic            progress_ucode;
   logic [W-1:0]    d;
`ifdef UCODE_PATCH_EN
   logic            ld_start;
   logic            ld_valid;
   logic [7:0]      ld_byte;
   logic            ld_ready;
   logic            ld_busy;
`endif

   int tests;
   int failed;

   logic [W-1:0] sb_q [$];

   typedef struct {
      logic            en;
      logic [ADRW-1:0] addr;
      logic [W-1:0]    exp;
   } vec_t;

   vec_t vecs [12];

   m_ucode_store #(
      .NEBR (NEBR),
      .ADRW (ADRW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .minx           (minx),
      .progress_ucode (progress_ucode),
      .d              (d)
`ifdef UCODE_PATCH_EN
      ,
      .ld_start       (ld_start),
      .ld_valid       (ld_valid),
      .ld_byte        (ld_byte),
      .ld_ready       (ld_ready),
      .ld_busy        (ld_busy)
`endif
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still ends with a report.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference init image: per slice, high byte = a xor A5, low byte = a + 49*slice.
   function automatic logic [W-1:0] imgWord(input int a);
      logic [W-1:0] w;
      w = '0;
      for (int s = 0; s < NEBR; s++) begin
         w[16*s+8 +: 8] = 8'((a ^ 165) & 255);
         w[16*s +: 8]   = 8'((a + 49 * s) % 256);
      end
      return w;
   endfunction

   // Word written at address a during the full load: byte b = a xor (37*b).
   function automatic logic [W-1:0] loadWord(input int a);
      logic [W-1:0] w;
      w = '0;
      for (int b = 0; b < 2 * NEBR; b++) begin
         w[8*b +: 8] = 8'((a ^ (37 * b)) & 255);
      end
      return w;
   endfunction

   task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [ADRW-1:0] addr, input logic [W-1:0] exp);
      progress_ucode = en;
      minx           = addr;
      sb_q.push_back(exp);
   endtask

   task automatic checkOutput(input string name);
      logic [W-1:0] exp;
      if (sb_q.size() == 0) begin
         tests++;
         failed++;
         $display("[TB] FAIL %s: actual=empty scoreboard required=entry", name);
      end else begin
         exp = sb_q.pop_front();
         checkValue(name, d, exp);
      end
   endtask

   task automatic stepCycle(input string name, input logic en, input logic [ADRW-1:0] addr,
                            input logic [W-1:0] exp);
      applyStimulus(en, addr, exp);
      @(posedge clk);
      #1;
      checkOutput(name);
   endtask

`ifdef UCODE_PATCH_EN
   task automatic pulseStart();
      ld_start = 1'b1;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int guard;
      guard = 0;
      while (!ld_ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkValue("ld_ready_wait", W'(ld_ready), W'(1));
      ld_valid = 1'b1;
      ld_byte  = b;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
   endtask
`endif

   initial begin
      logic [W-1:0] prev;
      tests          = 0;
      failed         = 0;
      rst_n          = 1'b0;
      minx           = '0;
      progress_ucode = 1'b0;
`ifdef UCODE_PATCH_EN
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_byte  = 8'h00;
`endif

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      checkValue("reset_d", d, '0);
`ifdef UCODE_PATCH_EN
      checkValue("reset_ld_ready", W'(ld_ready), '0);
      checkValue("reset_ld_busy", W'(ld_busy), '0);
`endif
      rst_n = 1'b1;

      // Reads disabled after reset keep d at 0.
      for (int i = 0; i < 5; i++) begin
         stepCycle("post_reset_hold", 1'b0, 8'h55, '0);
      end

      // Vector table: expected d follows the previous entry when disabled.
      vecs[0]  = '{1'b1, 8'h00, '0};
      vecs[1]  = '{1'b1, 8'h10, '0};
      vecs[2]  = '{1'b0, 8'h20, '0};
      vecs[3]  = '{1'b0, 8'h20, '0};
      vecs[4]  = '{1'b0, 8'h20, '0};
      vecs[5]  = '{1'b1, 8'hFF, '0};
      vecs[6]  = '{1'b1, 8'h01, '0};
      vecs[7]  = '{1'b0, 8'h80, '0};
      vecs[8]  = '{1'b1, 8'h80, '0};
      vecs[9]  = '{1'b1, 8'h7F, '0};
      vecs[10] = '{1'b1, 8'h80, '0};
      vecs[11] = '{1'b0, 8'h00, '0};
      prev = '0;
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].en) prev = imgWord(int'(vecs[i].addr));
         vecs[i].exp = prev;
      end
      for (int i = 0; i < 12; i++) begin
         stepCycle("table_read", vecs[i].en, vecs[i].addr, vecs[i].exp);
      end

      // Full address sweep against the init image.
      for (int a = 0; a < 256; a++) begin
         stepCycle("sweep_read", 1'b1, 8'(a), imgWord(a));
      end

      // Asynchronous reset in the middle of a cycle forces d to 0 at once.
      stepCycle("pre_reset_read", 1'b1, 8'h10, imgWord(16));
      progress_ucode = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("async_reset_d", d, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stepCycle("after_reset_hold", 1'b0, 8'h10, '0);
      stepCycle("after_reset_read", 1'b1, 8'h33, imgWord(51));

`ifdef UCODE_PATCH_EN
      // Single word load at address 0; ld_ready drops for the WRITE cycle only.
      pulseStart();
      checkValue("start_busy", W'(ld_busy), W'(1));
      for (int b = 1; b <= 6; b++) sendByte(8'(b));
      checkValue("write_ready_low", W'(ld_ready), '0);
      @(posedge clk);
      #1;
      checkValue("collect_ready_high", W'(ld_ready), W'(1));
      stepCycle("patched_word0", 1'b1, 8'h00, 48'h060504030201);

      // Aborted partial word: only the second sequence lands at address 0.
      pulseStart();
      for (int b = 0; b < 3; b++) sendByte(8'h11 + 8'(b));
      pulseStart();
      for (int b = 0; b < 6; b++) sendByte(8'hAA + 8'(b));
      @(posedge clk);
      #1;
      stepCycle("abort_word0", 1'b1, 8'h00, 48'hAFAEADACABAA);
      stepCycle("abort_word1", 1'b1, 8'h01, imgWord(1));

      // Full 256-word load, ending idle.
      pulseStart();
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 6; b++) sendByte(8'((a ^ (37 * b)) & 255));
      end
      @(posedge clk);
      #1;
      checkValue("full_load_busy", W'(ld_busy), '0);
      checkValue("full_load_ready", W'(ld_ready), '0);
      stepCycle("full_word0", 1'b1, 8'h00, loadWord(0));
      stepCycle("full_word1", 1'b1, 8'h01, loadWord(1));
      stepCycle("full_word128", 1'b1, 8'h80, loadWord(128));
      stepCycle("full_word255", 1'b1, 8'hFF, loadWord(255));

      // Reset mid-COLLECT: outputs clear immediately, stored words survive.
      pulseStart();
      sendByte(8'h5A);
      sendByte(8'hC3);
      #2;
      rst_n = 1'b0;
      #1;
      checkValue("mid_load_reset_d", d, '0);
      checkValue("mid_load_reset_busy", W'(ld_busy), '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stepCycle("kept_word5", 1'b1, 8'h05, loadWord(5));
      stepCycle("kept_word0", 1'b1, 8'h00, loadWord(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
